// File: rtl/jtframe_mdpad_pkg.sv
// Shared constants for the Mega Drive pad model.
// Button bit indices, special phases and the pin-row decoder.
package jtframe_mdpad_pkg;

  localparam int UP    = 0;
  localparam int DOWN  = 1;
  localparam int LEFT  = 2;
  localparam int RIGHT = 3;
  localparam int BTN_B = 4;
  localparam int BTN_C = 5;
  localparam int BTN_A = 6;
  localparam int START = 7;
  localparam int BTN_Z = 8;
  localparam int BTN_Y = 9;
  localparam int BTN_X = 10;
  localparam int MODE  = 11;

  localparam logic [2:0] PH_ID  = 3'd5;
  localparam logic [2:0] PH_XYZ = 3'd6;

  // Active-low pin row D5..D0 for a given protocol phase
  function automatic logic [5:0] pad_row(
    input logic [2:0]  ph,
    input logic [11:0] j
  );
    logic [5:0] r;
    r = 6'h3F;
    unique case (ph)
      3'd0, 3'd2, 3'd4:
        r = {~j[BTN_C], ~j[BTN_B], ~j[RIGHT],
             ~j[LEFT], ~j[DOWN], ~j[UP]};
      3'd1, 3'd3:
        r = {~j[START], ~j[BTN_A], 2'b00,
             ~j[DOWN], ~j[UP]};
      PH_ID:
        r = {~j[START], ~j[BTN_A], 4'b0000};
      PH_XYZ:
        r = {~j[BTN_C], ~j[BTN_B], ~j[MODE],
             ~j[BTN_X], ~j[BTN_Y], ~j[BTN_Z]};
      3'd7:
        r = {~j[START], ~j[BTN_A], 4'b1111};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jtframe_mdpad.sv
// Device-side Mega Drive 3/6-button pad.
// Answers TH with multiplexed active-low data and a 6-button cycle.
module jtframe_mdpad
  import jtframe_mdpad_pkg::*;
#(
  parameter int TMO  = 72000,
  parameter int TMOW = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode6,
  input  logic [11:0] joy,
  input  logic        th,
  output logic [5:0]  dout,
  output logic [2:0]  phase,
  output logic        th_edge
);

  localparam logic [TMOW-1:0] TMO_V = TMOW'(TMO);

  logic            th_m_q;
  logic            th_s_q;
  logic            th_l_q;
  logic            mode6_q;
  logic            edge_q;
  logic            edge_d;
  logic [2:0]      phase_q;
  logic [2:0]      phase_d;
  logic [TMOW-1:0] tmo_q;
  logic [TMOW-1:0] tmo_d;
  logic [5:0]      dout_q;
  logic [5:0]      dout_d;

  always_comb begin
    edge_d  = th_s_q ^ th_l_q;
    phase_d = phase_q;
    tmo_d   = tmo_q;
    if (edge_d) begin
      phase_d = phase_q + 3'd1;
      tmo_d   = '0;
    end else if (tmo_q != TMO_V) begin
      tmo_d = tmo_q + TMOW'(1);
      if (tmo_d == TMO_V)
        phase_d = {2'b00, ~th_s_q};
    end
    // th_l is the TH level that phase_q currently reflects
    dout_d = pad_row(mode6_q ? phase_q : {2'b00, ~th_l_q}, joy);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th_m_q  <= 1'b1;
      th_s_q  <= 1'b1;
      th_l_q  <= 1'b1;
      mode6_q <= 1'b0;
      edge_q  <= 1'b0;
      phase_q <= '0;
      tmo_q   <= '0;
      dout_q  <= 6'h3F;
    end else begin
      th_m_q  <= th;
      th_s_q  <= th_m_q;
      th_l_q  <= th_s_q;
      mode6_q <= mode6;
      edge_q  <= edge_d;
      phase_q <= phase_d;
      tmo_q   <= tmo_d;
      dout_q  <= dout_d;
    end
  end

  assign dout    = dout_q;
  assign phase   = phase_q;
  assign th_edge = edge_q;

endmodule

// File: tb/tb_jtframe_mdpad.sv
// Bench for jtframe_mdpad: directed protocol cases plus random TH,
// buttons and mode against a pin-history reference model.
module tb_jtframe_mdpad;

  localparam int TMO  = 40;
  localparam int TMOW = 6;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        mode6 = 1'b0;
  logic        th    = 1'b1;
  logic [11:0] joy   = '0;
  logic [5:0]  dout;
  logic [2:0]  phase;
  logic        th_edge;

  int nvec = 0;
  int nbad = 0;

  bit thh[$];
  bit mdh[$];
  int m_phase   = 0;
  int m_idle    = 0;
  int ncall     = 0;
  int last_edge = 0;

  logic [5:0] f00_tab [8] =
    '{6'h3F, 6'h33, 6'h3F, 6'h33, 6'h3F, 6'h30, 6'h30, 6'h3F};

  jtframe_mdpad #(.TMO(TMO), .TMOW(TMOW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mode6   (mode6),
    .joy     (joy),
    .th      (th),
    .dout    (dout),
    .phase   (phase),
    .th_edge (th_edge)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [11:0] got,
                     input logic [11:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pin levels before reset release count as TH high, mode6 low
  function automatic bit th_at(int k);
    return (k < 1) ? 1'b1 : thh[k-1];
  endfunction

  function automatic bit md_at(int k);
    return (k < 1) ? 1'b0 : mdh[k-1];
  endfunction

  function automatic logic [5:0] pins(int ph, logic [11:0] j);
    bit up, dn, lf, rt, b, c, a, st, z, y, x, md;
    {md, x, y, z, st, a, c, b, rt, lf, dn, up} = j;
    if (ph == 5) return {~st, ~a, 4'h0};
    if (ph == 6) return {~c, ~b, ~md, ~x, ~y, ~z};
    if (ph == 7) return {~st, ~a, 4'hF};
    if (ph % 2 == 1) return {~st, ~a, 2'b00, ~dn, ~up};
    return {~c, ~b, ~rt, ~lf, ~dn, ~up};
  endfunction

  task automatic model_reset();
    thh.delete();
    mdh.delete();
    m_phase = 0;
    m_idle  = 0;
  endtask

  task automatic cyc(input bit t, input bit m, input logic [11:0] j);
    logic [5:0] e_dout;
    bit         e_edge;
    int         k;
    int         eff;
    th    = t;
    mode6 = m;
    joy   = j;
    @(posedge clk);
    ncall++;
    thh.push_back(t);
    mdh.push_back(m);
    k      = thh.size();
    e_edge = th_at(k-2) != th_at(k-3);
    eff    = md_at(k-1) ? m_phase : (th_at(k-3) ? 0 : 1);
    e_dout = pins(eff, j);
    if (e_edge) begin
      m_phase   = (m_phase + 1) % 8;
      m_idle    = 0;
      last_edge = ncall;
    end else if (m_idle < TMO) begin
      m_idle++;
      if (m_idle == TMO) m_phase = th_at(k-2) ? 0 : 1;
    end
    @(negedge clk);
    chk("dout", dout, e_dout);
    chk("phase", phase, m_phase);
    chk("th_edge", th_edge, e_edge);
  endtask

  task automatic level(input bit t, input bit m, input int n,
                       input bit rj, input logic [11:0] j);
    for (int i = 0; i < n; i++)
      cyc(t, m, rj ? 12'($urandom) : j);
  endtask

  initial begin
    int e;
    int n;
    bit t;
    bit m;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_dout", dout, 6'h3F);
    chk("rst_phase", phase, 0);
    chk("rst_edge", th_edge, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    level(1'b1, 1'b0, 6, 1'b0, 12'h014);
    chk("left_b", dout, 6'h2B);
    level(1'b0, 1'b0, 4, 1'b0, 12'h0C0);
    chk("a_start", dout, 6'h03);
    chk("a_start_ph", phase, 1);

    t = 1'b1;
    for (int i = 0; i < 8; i++) begin
      level(t, 1'b1, 6, 1'b0, 12'hF00);
      chk("f00_row", dout, f00_tab[m_phase]);
      t = ~t;
    end

    for (int i = 0; i < 20 && !(m_phase == 3 && th == 1'b0); i++) begin
      t = (m_phase % 2 == 0) ? 1'b0 : 1'b1;
      level(t, 1'b1, 5, 1'b0, 12'h000);
    end
    chk("reach_ph3", phase, 3);
    e = last_edge;
    while (phase !== 3'd1 && ncall < e + 2 * TMO)
      cyc(1'b0, 1'b1, 12'h000);
    chk("tmo_lat", 12'(ncall - e), 12'(TMO));
    chk("tmo_ph", phase, 1);
    level(1'b1, 1'b1, 4, 1'b0, 12'h02A);
    chk("post_tmo_ph", phase, 2);
    chk("post_tmo_row", dout, 6'h15);

    e = last_edge;
    while (ncall < e + TMO - 3) cyc(1'b1, 1'b1, 12'h000);
    while (ncall < e + TMO) cyc(1'b0, 1'b1, 12'h000);
    chk("race_ph", phase, 3);
    chk("race_edge", th_edge, 1);
    e = e + TMO;
    while (ncall < e + TMO - 1) cyc(1'b0, 1'b1, 12'h000);
    chk("race_clr", phase, 3);
    cyc(1'b0, 1'b1, 12'h000);
    chk("race_tmo", phase, 1);

    t = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(5) == 0)
        n = $urandom_range(TMO + 3, TMO - 3);
      else
        n = $urandom_range(10, 4);
      if ($urandom_range(7) == 0) m = ~m;
      level(t, m, n, 1'b1, 12'h000);
      t = ~t;
    end

    for (int i = 0; i < 20 && m_phase != 6; i++) begin
      t = (m_phase % 2 == 0) ? 1'b0 : 1'b1;
      level(t, 1'b1, 5, 1'b0, 12'hF00);
    end
    chk("reach_ph6", phase, 6);
    th = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", dout, 6'h3F);
    chk("mid_rst_ph", phase, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    level(1'b1, 1'b1, 3, 1'b0, 12'h001);
    chk("post_rst_ph", phase, 0);
    chk("post_rst_row", dout, 6'h3E);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
